// File: rtl/mavg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mavg_pkg
// Description : Shared sizing helpers for the moving-average filter.
// Revision    : 1.0 - initial release
// ============================================================================
package mavg_pkg;

    localparam int c_MIN_TICK_DIV   = 2;
    localparam int c_MIN_LOG2_DEPTH = 1;
    localparam int c_MAX_LOG2_DEPTH = 6;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int sum_width(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

    function automatic int depth_of(input int log2_depth);
        return 1 << log2_depth;
    endfunction

    function automatic int tick_div(input int clk_freq, input int sample_hz);
        return clk_freq / sample_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_tick_gen
// Description : Free-running divider producing a registered one-cycle tick
//               every DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen
    import mavg_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == c_LAST);
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign tick_o = r_tick;

endmodule
`default_nettype wire

// File: rtl/moving_avg_filter.sv
`default_nettype none
// ============================================================================
// Module      : moving_avg_filter
// Description : Boxcar moving-average over 2**LOG2_DEPTH samples, one sample
//               accepted per sample tick via valid/ready. Define
//               MAVG_ROUND_EN for round-half-up output instead of truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module moving_avg_filter
    import mavg_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int CLK_FREQ   = 100000000,
    parameter int SAMPLE_HZ  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clear_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              overrun_o
);

    localparam int SUM_W    = sum_width(DATA_W, LOG2_DEPTH);
    localparam int DEPTH    = depth_of(LOG2_DEPTH);
    localparam int TICK_DIV = tick_div(CLK_FREQ, SAMPLE_HZ);

    generate
        if (TICK_DIV < c_MIN_TICK_DIV) begin : g_bad_tick_div
            $error("moving_avg_filter: CLK_FREQ/SAMPLE_HZ must be at least 2");
        end
        if (LOG2_DEPTH < c_MIN_LOG2_DEPTH || LOG2_DEPTH > c_MAX_LOG2_DEPTH) begin : g_bad_depth
            $error("moving_avg_filter: LOG2_DEPTH must be within 1..6");
        end
    endgenerate

    logic                  w_tick;
    logic                  w_hs;
    logic [DATA_W-1:0]     w_oldest;
    logic [SUM_W-1:0]      w_sum_next;
    logic [DATA_W-1:0]     w_mean;

    logic [DATA_W-1:0]     r_hist [DEPTH];
    logic [SUM_W-1:0]      r_sum;
    logic [LOG2_DEPTH-1:0] r_wptr;
    logic                  r_ready;
    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic                  r_overrun;

    sample_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (w_tick)
    );

    assign w_hs       = valid_i & r_ready;
    assign w_oldest   = r_hist[r_wptr];
    // sum always covers oldest, so this never underflows
    assign w_sum_next = r_sum + {{LOG2_DEPTH{1'b0}}, data_i} - {{LOG2_DEPTH{1'b0}}, w_oldest};

`ifdef MAVG_ROUND_EN
    localparam logic [SUM_W-1:0] c_HALF = SUM_W'(DEPTH / 2);
    logic [SUM_W-1:0] w_sum_rnd;
    assign w_sum_rnd = w_sum_next + c_HALF;
    assign w_mean    = w_sum_rnd[SUM_W-1:LOG2_DEPTH];
`else
    assign w_mean    = w_sum_next[SUM_W-1:LOG2_DEPTH];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_sum     <= '0;
            r_wptr    <= '0;
            r_ready   <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // a fresh tick reopens the window even if this cycle handshakes
            if (w_tick) begin
                r_ready <= 1'b1;
            end else if (w_hs) begin
                r_ready <= 1'b0;
            end

            if (clear_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_hist[i] <= '0;
                end
                r_sum     <= '0;
                r_wptr    <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_tick && r_ready) begin
                    r_overrun <= 1'b1;
                end
                if (w_hs) begin
                    r_hist[r_wptr] <= data_i;
                    r_sum          <= w_sum_next;
                    r_wptr         <= r_wptr + 1'b1;
                    r_data         <= w_mean;
                    r_valid        <= 1'b1;
                end
            end
        end
    end

    assign ready_o   = r_ready;
    assign valid_o   = r_valid;
    assign data_o    = r_data;
    assign overrun_o = r_overrun;

endmodule
`default_nettype wire
